// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//
// Round-robin arbiter that shares one UART transmitter between several byte
// sources. A winning byte is latched, the transmitter is started with a
// one-cycle strobe, the arbiter waits for the transmitter's done pulse and
// then holds off for GAP_TICKS idle cycles before arbitrating again.
//
// Ports:
//   clk_i        system clock
//   reset_i      asynchronous, active-high reset
//   req_valid_i  per-requester byte-available flag
//   req_data_i   packed bytes, requester k at [k*WORD_BITS +: WORD_BITS]
//   req_ready_o  one-cycle accept pulse to the granted requester
//   grant_o      one-hot owner of the transmitter, zero when idle
//   tx_start_o   one-cycle start strobe to uart_tx
//   tx_data_o    byte for uart_tx, stable from start until done
//   tx_done_i    one-cycle completion pulse from uart_tx
//   busy_o       high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int WORD_BITS = 8,
    parameter int GAP_TICKS = 16
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ*WORD_BITS-1:0] req_data_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    output logic [NUM_REQ-1:0]           grant_o,
    output logic                         tx_start_o,
    output logic [WORD_BITS-1:0]         tx_data_o,
    input  logic                         tx_done_i,
    output logic                         busy_o
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_START     = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } state_t;

    // Registered state and outputs
    state_t                 r_state;
    logic [PTR_W-1:0]       r_ptr;
    logic [CNT_W-1:0]       r_cnt;
    logic [NUM_REQ-1:0]     r_grant;
    logic [NUM_REQ-1:0]     r_ready;
    logic                   r_tx_start;
    logic [WORD_BITS-1:0]   r_tx_data;
    logic                   r_busy;

    // Next-state values
    state_t                 w_state_nxt;
    logic [PTR_W-1:0]       w_ptr_nxt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [NUM_REQ-1:0]     w_grant_nxt;
    logic [NUM_REQ-1:0]     w_ready_nxt;
    logic                   w_tx_start_nxt;
    logic [WORD_BITS-1:0]   w_tx_data_nxt;
    logic                   w_busy_nxt;

    // Arbitration result
    logic [PTR_W:0]         w_pick;
    logic                   w_found;
    logic [PTR_W-1:0]       w_win;
    logic [NUM_REQ-1:0]     w_onehot;

    // First set valid bit scanning upward from ptr with wrap-around.
    // Returns {found, index}.
    function automatic logic [PTR_W:0] rr_pick(
        input logic [NUM_REQ-1:0] valid,
        input logic [PTR_W-1:0]   ptr
    );
        logic [PTR_W:0]   v_res;
        logic [PTR_W-1:0] v_pos;
        int unsigned      v_idx;
        v_res = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            v_idx = (32'(ptr) + 32'(i)) % 32'(NUM_REQ);
            v_pos = v_idx[PTR_W-1:0];
            v_res = (!v_res[PTR_W] && valid[v_pos]) ? {1'b1, v_pos} : v_res;
        end
        return v_res;
    endfunction

    // Round-robin winner selection and its one-hot form
    always_comb begin
        w_pick          = rr_pick(req_valid_i, r_ptr);
        w_found         = w_pick[PTR_W];
        w_win           = w_pick[PTR_W-1:0];
        w_onehot        = '0;
        w_onehot[w_win] = 1'b1;
    end

    // Next-state and next-output logic
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_cnt_nxt      = r_cnt;
        w_grant_nxt    = r_grant;
        w_ready_nxt    = '0;
        w_tx_start_nxt = 1'b0;
        w_tx_data_nxt  = r_tx_data;

        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_tx_data_nxt  = req_data_i[w_win*WORD_BITS +: WORD_BITS];
                    w_grant_nxt    = w_onehot;
                    w_ready_nxt    = w_onehot;
                    w_tx_start_nxt = 1'b1;
                    w_ptr_nxt      = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + PTR_W'(1);
                    w_state_nxt    = ST_START;
                end else begin
                    w_grant_nxt    = '0;
                end
            end
            // Strobe cycle: valid and done are deliberately not looked at here
            ST_START: begin
                w_state_nxt = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (tx_done_i) begin
                    if (GAP_TICKS == 0) begin
                        w_grant_nxt = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_cnt_nxt   = CNT_W'(GAP_TICKS);
                        w_state_nxt = ST_GAP;
                    end
                end else begin
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            // Leaving on the count of 1 makes the gap exactly GAP_TICKS cycles
            ST_GAP: begin
                if (r_cnt <= CNT_W'(1)) begin
                    w_grant_nxt = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt - CNT_W'(1);
                end
            end
            default: begin
                w_grant_nxt = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State, pointer, counter and registered outputs
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_cnt      <= '0;
            r_grant    <= '0;
            r_ready    <= '0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_cnt      <= w_cnt_nxt;
            r_grant    <= w_grant_nxt;
            r_ready    <= w_ready_nxt;
            r_tx_start <= w_tx_start_nxt;
            r_tx_data  <= w_tx_data_nxt;
            r_busy     <= w_busy_nxt;
        end
    end

    assign req_ready_o = r_ready;
    assign grant_o     = r_grant;
    assign tx_start_o  = r_tx_start;
    assign tx_data_o   = r_tx_data;
    assign busy_o      = r_busy;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//
// Directed bench for uart_tx_arbiter. Three instances:
//   A: NUM_REQ=2, GAP_TICKS=4  (single, simultaneous, spurious done, reset)
//   B: NUM_REQ=3, GAP_TICKS=4  (fairness)
//   C: NUM_REQ=2, GAP_TICKS=0  (no gap, back-to-back)
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

    logic clk;
    int   total;
    int   bad;

    // Instance A
    logic        a_rst;
    logic [1:0]  a_valid;
    logic [15:0] a_data;
    logic [1:0]  a_ready;
    logic [1:0]  a_grant;
    logic        a_start;
    logic [7:0]  a_txd;
    logic        a_done;
    logic        a_busy;

    // Instance B
    logic        b_rst;
    logic [2:0]  b_valid;
    logic [23:0] b_data;
    logic [2:0]  b_ready;
    logic [2:0]  b_grant;
    logic        b_start;
    logic [7:0]  b_txd;
    logic        b_done;
    logic        b_busy;

    // Instance C
    logic        c_rst;
    logic [1:0]  c_valid;
    logic [15:0] c_data;
    logic [1:0]  c_ready;
    logic [1:0]  c_grant;
    logic        c_start;
    logic [7:0]  c_txd;
    logic        c_done;
    logic        c_busy;

    uart_tx_arbiter #(.NUM_REQ(2), .WORD_BITS(8), .GAP_TICKS(4)) u_a (
        .clk_i(clk), .reset_i(a_rst), .req_valid_i(a_valid), .req_data_i(a_data),
        .req_ready_o(a_ready), .grant_o(a_grant), .tx_start_o(a_start),
        .tx_data_o(a_txd), .tx_done_i(a_done), .busy_o(a_busy)
    );

    uart_tx_arbiter #(.NUM_REQ(3), .WORD_BITS(8), .GAP_TICKS(4)) u_b (
        .clk_i(clk), .reset_i(b_rst), .req_valid_i(b_valid), .req_data_i(b_data),
        .req_ready_o(b_ready), .grant_o(b_grant), .tx_start_o(b_start),
        .tx_data_o(b_txd), .tx_done_i(b_done), .busy_o(b_busy)
    );

    uart_tx_arbiter #(.NUM_REQ(2), .WORD_BITS(8), .GAP_TICKS(0)) u_c (
        .clk_i(clk), .reset_i(c_rst), .req_valid_i(c_valid), .req_data_i(c_data),
        .req_ready_o(c_ready), .grant_o(c_grant), .tx_start_o(c_start),
        .tx_data_o(c_txd), .tx_done_i(c_done), .busy_o(c_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
        end
    endtask

    initial begin
        logic       got;
        logic [2:0] exp_oh;
        logic [7:0] exp_byte;

        total = 0;
        bad   = 0;
        a_rst = 1'b1; a_valid = 2'b00; a_data = 16'h0000; a_done = 1'b0;
        b_rst = 1'b1; b_valid = 3'b000; b_data = 24'h000000; b_done = 1'b0;
        c_rst = 1'b1; c_valid = 2'b00; c_data = 16'h0000; c_done = 1'b0;
        step(2);

        // Reset state
        chk("rst_grant", 32'(a_grant), 32'h0);
        chk("rst_start", 32'(a_start), 32'h0);
        chk("rst_ready", 32'(a_ready), 32'h0);
        chk("rst_txd",   32'(a_txd),   32'h0);
        chk("rst_busy",  32'(a_busy),  32'h0);

        // ---- 1. Single request on A ----
        a_rst   = 1'b0;
        a_valid = 2'b01;
        a_data  = 16'h00CC;
        step(1);
        chk("t1_start", 32'(a_start), 32'h1);
        chk("t1_txd",   32'(a_txd),   32'hCC);
        chk("t1_grant", 32'(a_grant), 32'h1);
        chk("t1_ready", 32'(a_ready), 32'h1);
        chk("t1_busy",  32'(a_busy),  32'h1);
        a_valid = 2'b00;
        a_data  = 16'h0000;
        step(1);
        chk("t1_start_pulse", 32'(a_start), 32'h0);
        chk("t1_ready_pulse", 32'(a_ready), 32'h0);
        chk("t1_txd_hold",    32'(a_txd),   32'hCC);
        step(19);
        chk("t1_wait_busy",  32'(a_busy),  32'h1);
        chk("t1_wait_grant", 32'(a_grant), 32'h1);
        a_done = 1'b1;
        step(1);
        a_done = 1'b0;
        chk("t1_gap_busy1", 32'(a_busy), 32'h1);
        step(3);
        chk("t1_gap_busy4", 32'(a_busy), 32'h1);
        step(1);
        chk("t1_idle_busy",  32'(a_busy),  32'h0);
        chk("t1_idle_grant", 32'(a_grant), 32'h0);
        chk("t1_idle_txd",   32'(a_txd),   32'hCC);

        // ---- 2. Simultaneous requests on A from reset release ----
        a_rst   = 1'b1;
        a_valid = 2'b11;
        a_data  = 16'h2211;
        step(1);
        a_rst = 1'b0;
        step(1);
        chk("t2_first_start", 32'(a_start), 32'h1);
        chk("t2_first_txd",   32'(a_txd),   32'h11);
        chk("t2_first_grant", 32'(a_grant), 32'h1);
        chk("t2_first_ready", 32'(a_ready), 32'h1);
        a_valid = 2'b10;
        step(1);
        chk("t2_ready_once0", 32'(a_ready), 32'h0);
        a_done = 1'b1;
        step(1);
        a_done = 1'b0;
        step(4);
        chk("t2_idle_start", 32'(a_start), 32'h0);
        chk("t2_idle_ready", 32'(a_ready), 32'h0);
        chk("t2_idle_grant", 32'(a_grant), 32'h0);
        step(1);
        chk("t2_second_start", 32'(a_start), 32'h1);
        chk("t2_second_txd",   32'(a_txd),   32'h22);
        chk("t2_second_grant", 32'(a_grant), 32'h2);
        chk("t2_second_ready", 32'(a_ready), 32'h2);
        a_valid = 2'b00;
        step(1);
        chk("t2_ready_once1", 32'(a_ready), 32'h0);
        a_done = 1'b1;
        step(1);
        a_done = 1'b0;
        step(5);
        chk("t2_back_idle", 32'(a_busy), 32'h0);

        // ---- 4. Spurious done in IDLE and START ----
        a_done = 1'b1;
        step(1);
        a_done = 1'b0;
        chk("t4_idle_busy",  32'(a_busy),  32'h0);
        chk("t4_idle_start", 32'(a_start), 32'h0);
        chk("t4_idle_grant", 32'(a_grant), 32'h0);
        a_valid = 2'b01;
        a_data  = 16'h0077;
        step(1);
        chk("t4_start", 32'(a_start), 32'h1);
        a_valid = 2'b00;
        a_done  = 1'b1;
        step(1);
        a_done = 1'b0;
        chk("t4_after_start_busy",  32'(a_busy),  32'h1);
        chk("t4_after_start_grant", 32'(a_grant), 32'h1);
        step(6);
        chk("t4_still_waiting", 32'(a_busy),  32'h1);
        chk("t4_txd_held",      32'(a_txd),   32'h77);

        // ---- 5. Asynchronous reset in WAIT_DONE ----
        #2;
        a_rst = 1'b1;
        #1;
        chk("t5_async_busy",  32'(a_busy),  32'h0);
        chk("t5_async_grant", 32'(a_grant), 32'h0);
        chk("t5_async_txd",   32'(a_txd),   32'h0);
        chk("t5_async_start", 32'(a_start), 32'h0);
        chk("t5_async_ready", 32'(a_ready), 32'h0);
        a_valid = 2'b10;
        a_data  = 16'h5A00;
        step(1);
        a_rst = 1'b0;
        step(1);
        chk("t5_req1_start", 32'(a_start), 32'h1);
        chk("t5_req1_grant", 32'(a_grant), 32'h2);
        chk("t5_req1_txd",   32'(a_txd),   32'h5A);
        chk("t5_req1_ready", 32'(a_ready), 32'h2);
        a_valid = 2'b00;

        // ---- 3. Fairness on B ----
        b_data  = 24'hA2A1A0;
        b_valid = 3'b111;
        b_rst   = 1'b0;
        for (int n = 0; n < 6; n++) begin
            got = 1'b0;
            for (int w = 0; w < 30 && !got; w++) begin
                @(negedge clk);
                if (b_start) begin
                    got = 1'b1;
                end
            end
            exp_oh   = 3'b001 << (n % 3);
            exp_byte = 8'hA0 + 8'(n % 3);
            chk("t3_start_seen", 32'(got),     32'h1);
            chk("t3_txd",        32'(b_txd),   32'(exp_byte));
            chk("t3_grant",      32'(b_grant), 32'(exp_oh));
            chk("t3_ready",      32'(b_ready), 32'(exp_oh));
            step(1);
            b_done = 1'b1;
            step(1);
            b_done = 1'b0;
        end
        b_valid = 3'b000;

        // ---- 6. GAP_TICKS=0 back-to-back on C ----
        c_valid = 2'b01;
        c_data  = 16'h00CC;
        c_rst   = 1'b0;
        step(1);
        chk("t6_first_start", 32'(c_start), 32'h1);
        chk("t6_first_txd",   32'(c_txd),   32'hCC);
        c_data = 16'h003C;
        step(1);
        c_done = 1'b1;
        step(1);
        c_done = 1'b0;
        chk("t6_idle_start", 32'(c_start), 32'h0);
        chk("t6_idle_busy",  32'(c_busy),  32'h0);
        chk("t6_idle_grant", 32'(c_grant), 32'h0);
        step(1);
        chk("t6_second_start", 32'(c_start), 32'h1);
        chk("t6_second_txd",   32'(c_txd),   32'h3C);
        chk("t6_second_grant", 32'(c_grant), 32'h1);
        chk("t6_second_ready", 32'(c_ready), 32'h1);
        c_valid = 2'b00;
        step(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
